// File: rtl/alu_arith_32_if.sv
// Operand/result bundle for alu_arith_32: request fields in, registered result and flags out.
interface alu_arith_32_if;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic [31:0] res;
  logic        out_valid;
  logic        zero;
  logic        carry;
  logic        ovf;

  modport master (output in_valid, a, b, op,
                  input  res, out_valid, zero, carry, ovf);
  modport slave  (input  in_valid, a, b, op,
                  output res, out_valid, zero, carry, ovf);
endinterface

// File: rtl/alu_arith_32.sv
// Single-cycle 32-bit arithmetic unit: ADD/SUB/INC/DEC on one shared adder, signed SLT/SGT,
// registered result and flags.
module alu_arith_32 #(
  parameter logic [31:0] STEP = 32'd4
) (
  input logic         clk,
  input logic         rst_n,
  alu_arith_32_if.slave bus
);

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        carry;
    logic        ovf;
  } rsp_t;

  rsp_t        rsp_nx, rsp_q;
  logic        out_valid_q;
  logic        sub;
  logic [31:0] opb, opb_x;
  logic [32:0] sum;
  logic        lt, gt;

  // op[2] swaps b for STEP; op[0] turns the add into a two's-complement subtract.
  assign sub   = bus.op[0];
  assign opb   = bus.op[2] ? STEP : bus.b;
  assign opb_x = opb ^ {32{sub}};
  assign sum   = {1'b0, bus.a} + {1'b0, opb_x} + {32'b0, sub};

  // Direct signed compare, so overflow of a-b cannot corrupt the result.
  assign lt = $signed(bus.a) < $signed(bus.b);
  assign gt = $signed(bus.a) > $signed(bus.b);

  always_comb begin
    rsp_nx = '0;
    case (bus.op)
      3'b000, 3'b001, 3'b100, 3'b101: begin
        rsp_nx.res   = sum[31:0];
        rsp_nx.carry = sum[32];
        rsp_nx.ovf   = (bus.a[31] == opb_x[31]) && (sum[31] != bus.a[31]);
      end
      3'b010:  rsp_nx.res = {31'b0, lt};
      3'b011:  rsp_nx.res = {31'b0, gt};
      default: rsp_nx.res = '0;
    endcase
    rsp_nx.zero = (rsp_nx.res == 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) rsp_q <= rsp_nx;
    end
  end

  assign bus.res       = rsp_q.res;
  assign bus.zero      = rsp_q.zero;
  assign bus.carry     = rsp_q.carry;
  assign bus.ovf       = rsp_q.ovf;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_arith_32.sv
// Directed bench for alu_arith_32: one task per feature, hand-computed expectations.
module tb_alu_arith_32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  alu_arith_32_if bus();
  alu_arith_32 #(.STEP(32'd4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // {out_valid, zero, carry, ovf}
  logic [3:0] flags;
  assign flags = {bus.out_valid, bus.zero, bus.carry, bus.ovf};

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, SLT = 3'b010, SGT = 3'b011,
                         INC = 3'b100, DEC = 3'b101, RSV0 = 3'b110, RSV1 = 3'b111;

  // Present one operation at the falling edge, let the rising edge capture it, sample 1ns later.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    #2;
    checks++;
    if ({bus.res, flags} !== 36'h0) begin
      errors++; $display("FAIL reset_state res=%h flags=%b exp res=0 flags=0000", bus.res, flags);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add();
    issue(ADD, 32'h7FFFFFFF, 32'd1);
    checks++;
    if (bus.res !== 32'h80000000 || flags !== 4'b1001) begin
      errors++; $display("FAIL add_ovf res=%h flags=%b exp res=80000000 flags=1001", bus.res, flags);
    end
    issue(ADD, 32'hFFFFFFFF, 32'd1);
    checks++;
    if (bus.res !== 32'h0 || flags !== 4'b1110) begin
      errors++; $display("FAIL add_wrap res=%h flags=%b exp res=00000000 flags=1110", bus.res, flags);
    end
  endtask

  task automatic test_sub();
    issue(SUB, 32'd5, 32'd5);
    checks++;
    if (bus.res !== 32'h0 || flags !== 4'b1110) begin
      errors++; $display("FAIL sub_eq res=%h flags=%b exp res=00000000 flags=1110", bus.res, flags);
    end
    issue(SUB, 32'd0, 32'd1);
    checks++;
    if (bus.res !== 32'hFFFFFFFF || flags !== 4'b1000) begin
      errors++; $display("FAIL sub_borrow res=%h flags=%b exp res=ffffffff flags=1000", bus.res, flags);
    end
    issue(SUB, 32'h80000000, 32'd1);
    checks++;
    if (bus.res !== 32'h7FFFFFFF || flags !== 4'b1011) begin
      errors++; $display("FAIL sub_ovf res=%h flags=%b exp res=7fffffff flags=1011", bus.res, flags);
    end
  endtask

  task automatic test_compare();
    issue(SLT, 32'h80000000, 32'd1);
    checks++;
    if (bus.res !== 32'd1 || flags !== 4'b1000) begin
      errors++; $display("FAIL slt_neg res=%h flags=%b exp res=00000001 flags=1000", bus.res, flags);
    end
    issue(SGT, 32'h80000000, 32'd1);
    checks++;
    if (bus.res !== 32'd0 || flags !== 4'b1100) begin
      errors++; $display("FAIL sgt_neg res=%h flags=%b exp res=00000000 flags=1100", bus.res, flags);
    end
    issue(SLT, 32'd7, 32'd7);
    checks++;
    if (bus.res !== 32'd0 || flags !== 4'b1100) begin
      errors++; $display("FAIL slt_eq res=%h flags=%b exp res=00000000 flags=1100", bus.res, flags);
    end
    issue(SGT, 32'd7, 32'd7);
    checks++;
    if (bus.res !== 32'd0 || flags !== 4'b1100) begin
      errors++; $display("FAIL sgt_eq res=%h flags=%b exp res=00000000 flags=1100", bus.res, flags);
    end
    // a-b overflows here: max positive vs min negative
    issue(SGT, 32'h7FFFFFFF, 32'h80000000);
    checks++;
    if (bus.res !== 32'd1 || flags !== 4'b1000) begin
      errors++; $display("FAIL sgt_ovf res=%h flags=%b exp res=00000001 flags=1000", bus.res, flags);
    end
    issue(SLT, 32'h7FFFFFFF, 32'h80000000);
    checks++;
    if (bus.res !== 32'd0 || flags !== 4'b1100) begin
      errors++; $display("FAIL slt_ovf res=%h flags=%b exp res=00000000 flags=1100", bus.res, flags);
    end
  endtask

  task automatic test_incdec();
    issue(INC, 32'hFFFFFFFC, 32'hDEADBEEF);
    checks++;
    if (bus.res !== 32'h0 || flags !== 4'b1110) begin
      errors++; $display("FAIL inc_wrap res=%h flags=%b exp res=00000000 flags=1110", bus.res, flags);
    end
    issue(DEC, 32'd0, 32'hDEADBEEF);
    checks++;
    if (bus.res !== 32'hFFFFFFFC || flags !== 4'b1000) begin
      errors++; $display("FAIL dec_borrow res=%h flags=%b exp res=fffffffc flags=1000", bus.res, flags);
    end
    issue(INC, 32'h7FFFFFFE, 32'd0);
    checks++;
    if (bus.res !== 32'h80000002 || flags !== 4'b1001) begin
      errors++; $display("FAIL inc_ovf res=%h flags=%b exp res=80000002 flags=1001", bus.res, flags);
    end
  endtask

  task automatic test_back_to_back();
    issue(ADD, 32'd1, 32'd2);
    checks++;
    if (bus.res !== 32'd3 || flags !== 4'b1000) begin
      errors++; $display("FAIL b2b_add res=%h flags=%b exp res=00000003 flags=1000", bus.res, flags);
    end
    issue(SUB, 32'd9, 32'd4);
    checks++;
    if (bus.res !== 32'd5 || flags !== 4'b1010) begin
      errors++; $display("FAIL b2b_sub res=%h flags=%b exp res=00000005 flags=1010", bus.res, flags);
    end
    issue(SGT, 32'd3, 32'hFFFFFFFF);
    checks++;
    if (bus.res !== 32'd1 || flags !== 4'b1000) begin
      errors++; $display("FAIL b2b_sgt res=%h flags=%b exp res=00000001 flags=1000", bus.res, flags);
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.op = ADD; bus.a = 32'd100; bus.b = 32'd100;
    @(posedge clk); #1;
    checks++;
    if (bus.res !== 32'd1 || flags !== 4'b0000) begin
      errors++; $display("FAIL idle_hold res=%h flags=%b exp res=00000001 flags=0000", bus.res, flags);
    end
  endtask

  task automatic test_reset_mid();
    issue(ADD, 32'd10, 32'd20);
    checks++;
    if (bus.res !== 32'd30 || flags !== 4'b1000) begin
      errors++; $display("FAIL pre_reset res=%h flags=%b exp res=0000001e flags=1000", bus.res, flags);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.res, flags} !== 36'h0) begin
      errors++; $display("FAIL async_reset res=%h flags=%b exp res=0 flags=0000", bus.res, flags);
    end
    @(negedge clk); rst_n = 1'b1;
    issue(RSV0, 32'd5, 32'd5);
    checks++;
    if (bus.res !== 32'd0 || flags !== 4'b1100) begin
      errors++; $display("FAIL rsv110 res=%h flags=%b exp res=00000000 flags=1100", bus.res, flags);
    end
    issue(RSV1, 32'hFFFFFFFF, 32'd1);
    checks++;
    if (bus.res !== 32'd0 || flags !== 4'b1100) begin
      errors++; $display("FAIL rsv111 res=%h flags=%b exp res=00000000 flags=1100", bus.res, flags);
    end
    @(negedge clk); bus.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_compare();
    test_incdec();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout sim_time=%0t exp finish before 100000", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_arith_32.md
ALU_ARITH_32 -- requirements
Module: alu_arith_32

Interface
REQ-001 Parameter: STEP, default 32'd4, constant used by INC/DEC operations.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operands and op are valid this cycle.
REQ-005 a  input  32  operand A (two's complement where signed).
REQ-006 b  input  32  operand B (two's complement where signed).
REQ-007 op  input  3  operation select (encoding in REQ-011).
REQ-008 res  output  32  registered result.
REQ-009 out_valid  output  1  res/flags hold the result of an accepted operation.
REQ-010 zero, carry, ovf  output  1 each  registered flags.

Function
REQ-011 The block SHALL decode op as: 000 ADD (a+b), 001 SUB (a-b), 010 SLT, 011 SGT, 100 INC (a+STEP), 101 DEC (a-STEP), 110/111 reserved.
- Encoding mirrors the ALU convention: op[0]=0 selects add/increment, op[0]=1 selects subtract/decrement.
REQ-012 ADD/SUB SHALL use one shared 32-bit adder: a + (b XOR {32{op[0]}}) + op[0].
REQ-013 INC/DEC SHALL use the same add/subtract rule with STEP in place of b; b is ignored.
REQ-014 Arithmetic SHALL wrap modulo 2^32; no saturation.
REQ-015 carry SHALL be the adder carry-out bit 32 for ADD/SUB/INC/DEC.
- For SUB/DEC, carry=1 means no borrow (a >= subtrahend unsigned).
REQ-016 ovf SHALL be signed overflow for ADD/SUB/INC/DEC: operand signs equal (after B inversion) and result sign differs.
REQ-017 SLT SHALL return 32'd1 if signed a < signed b, else 32'd0; the comparison SHALL be correct even when a-b overflows.
REQ-018 SGT SHALL return 32'd1 if signed a > signed b, else 32'd0; a==b gives 0 for both SLT and SGT.
REQ-019 For SLT/SGT and reserved ops, carry and ovf SHALL be 0.
REQ-020 Reserved ops SHALL produce res=0 and zero=1.
REQ-021 zero SHALL equal (res_next == 0) for every op.
REQ-022 Latency SHALL be one cycle: a transfer with in_valid=1 at edge N appears on res/flags after edge N, with out_valid=1.
REQ-023 When in_valid=0 at an edge, res and flags SHALL hold their previous values and out_valid SHALL go 0.
REQ-024 Back-to-back in_valid=1 SHALL be accepted every cycle (throughput 1/cycle); there is no backpressure.
REQ-025 Outputs SHALL come only from registers (no combinational path from inputs to outputs).

Reset
REQ-026 While rst_n=0, res=0, zero=0, carry=0, ovf=0, out_valid=0, asynchronously and independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight result; the first edge after rst_n rises with in_valid=1 produces a normal result one cycle later.

Verification
REQ-028 ADD a=0x7FFFFFFF, b=1 -> res=0x80000000, ovf=1, carry=0, zero=0, out_valid=1 one cycle later.
REQ-029 SUB a=5, b=5 -> res=0, zero=1, carry=1, ovf=0; SUB a=0, b=1 -> res=0xFFFFFFFF, carry=0.
REQ-030 SLT a=0x80000000, b=1 -> res=1; SGT with same operands -> res=0; SLT a=b=7 -> res=0, zero=1.
REQ-031 INC a=0xFFFFFFFC -> res=0, carry=1, zero=1; DEC a=0 -> res=0xFFFFFFFC, carry=0; b=0xDEADBEEF has no effect.
REQ-032 Stream ADD(1,2), SUB(9,4), SGT(3,-1) on consecutive edges -> res 3, 5, 1 on consecutive cycles; then in_valid=0 -> res holds 1, out_valid=0.
REQ-033 Assert rst_n=0 between clock edges while out_valid=1 -> all outputs 0 immediately; op=110 after release -> res=0, zero=1.
